// File: rtl/difftest_commit_sequencer_if.sv
// Trace-side and checker-side signals of the difftest commit sequencer.
// The slave modport is the sequencer; the master modport is the core/checker environment.
interface difftest_commit_sequencer_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = 64,
  parameter int INST_BITS    = 32
);
  logic [COMMIT_WIDTH-1:0]           in_valid;
  logic [XLEN*COMMIT_WIDTH-1:0]      in_pc;
  logic [INST_BITS*COMMIT_WIDTH-1:0] in_inst;
  logic [XLEN*COMMIT_WIDTH-1:0]      in_wdata;
  logic [XLEN*COMMIT_WIDTH-1:0]      in_mstatus;
  logic [COMMIT_WIDTH-1:0]           in_check;
  logic                              in_trap;
  logic [XLEN-1:0]                   in_cause;
  logic                              finish_req;

  logic                              out_valid;
  logic                              out_ready;
  logic                              out_is_trap;
  logic [XLEN-1:0]                   out_pc;
  logic [INST_BITS-1:0]              out_inst;
  logic [XLEN-1:0]                   out_wdata;
  logic [XLEN-1:0]                   out_mstatus;
  logic                              out_check;

  logic                              almost_full;
  logic                              overflow;
  logic                              done;
  logic [63:0]                       retired_cnt;

  modport master (
    output in_valid, in_pc, in_inst, in_wdata, in_mstatus, in_check,
           in_trap, in_cause, finish_req, out_ready,
    input  out_valid, out_is_trap, out_pc, out_inst, out_wdata, out_mstatus,
           out_check, almost_full, overflow, done, retired_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_wdata, in_mstatus, in_check,
           in_trap, in_cause, finish_req, out_ready,
    output out_valid, out_is_trap, out_pc, out_inst, out_wdata, out_mstatus,
           out_check, almost_full, overflow, done, retired_cnt
  );
endinterface

// File: rtl/difftest_commit_sequencer.sv
// Compacts up to COMMIT_WIDTH retirements plus one trap per cycle into a FIFO, hands them
// one at a time to the co-simulation checker, and sequences end of test (drain, done, overflow).
module difftest_commit_sequencer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = 64,
  parameter int INST_BITS    = 32,
  parameter int DEPTH        = 16
) (
  input logic clock,
  input logic reset,
  difftest_commit_sequencer_if.slave bus
);
  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = AW + 1;
  localparam int AF_MARGIN = 2 * (COMMIT_WIDTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE, ERROR} state_t;

  typedef struct packed {
    logic                 is_trap;
    logic [XLEN-1:0]      pc;
    logic [INST_BITS-1:0] inst;
    logic [XLEN-1:0]      wdata;
    logic [XLEN-1:0]      mstatus;
    logic                 check;
  } entry_t;

  state_t        state;
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, occ, free_slots, n_in;
  logic [AW-1:0] lane_slot [COMMIT_WIDTH];
  logic [AW-1:0] trap_slot;
  entry_t        lane_entry [COMMIT_WIDTH];
  entry_t        trap_entry;
  entry_t        head;
  logic          running, enq_ok, enq_overflow, out_valid_i, pop, drain_empty;
  logic          done_q, overflow_q;
  logic [63:0]   retired_q;

  assign occ        = wr_ptr - rd_ptr;
  assign free_slots = PW'(DEPTH) - occ;
  assign running    = (state == RUN);
  assign head       = mem[rd_ptr[AW-1:0]];

  // NOTE: every variable here gets a value before any conditional path, so no latch is inferred.
  always_comb begin
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_slot[i]  = wr_ptr[AW-1:0] + acc[AW-1:0];
      lane_entry[i] = '{is_trap: 1'b0,
                        pc:      bus.in_pc[i*XLEN +: XLEN],
                        inst:    bus.in_inst[i*INST_BITS +: INST_BITS],
                        wdata:   bus.in_wdata[i*XLEN +: XLEN],
                        mstatus: bus.in_mstatus[i*XLEN +: XLEN],
                        check:   bus.in_check[i]};
      acc = acc + PW'(bus.in_valid[i]);
    end
    trap_slot  = wr_ptr[AW-1:0] + acc[AW-1:0];
    trap_entry = '{is_trap: 1'b1, pc: '0, inst: '0, wdata: bus.in_cause, mstatus: '0, check: 1'b0};
    n_in       = acc + PW'(bus.in_trap);
  end

  // Room is judged against pre-cycle occupancy; a same-cycle pop earns no credit.
  assign enq_ok       = running && (n_in != '0) && (n_in <= free_slots);
  assign enq_overflow = running && (n_in > free_slots);
  assign out_valid_i  = (occ != '0) && (state == RUN || state == DRAIN);
  assign pop          = out_valid_i && bus.out_ready;
  assign drain_empty  = (occ == '0) || (occ == PW'(1) && pop);

  // NOTE: non-blocking assignments so pointers, counters and state all update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      retired_q  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (enq_ok) wr_ptr <= wr_ptr + n_in;
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (!head.is_trap) retired_q <= retired_q + 64'd1;
      end
      unique case (state)
        RUN: begin
          if (enq_overflow) begin
            state      <= ERROR;
            overflow_q <= 1'b1;
          end else if (bus.finish_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the entry store is not reset; the pointers decide which slots are live and outputs are gated by out_valid.
  always_ff @(posedge clock) begin
    if (enq_ok) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (bus.in_valid[i]) mem[lane_slot[i]] <= lane_entry[i];
      end
      if (bus.in_trap) mem[trap_slot] <= trap_entry;
    end
  end

  assign bus.out_valid   = out_valid_i;
  assign bus.out_is_trap = out_valid_i & head.is_trap;
  assign bus.out_pc      = out_valid_i ? head.pc      : '0;
  assign bus.out_inst    = out_valid_i ? head.inst    : '0;
  assign bus.out_wdata   = out_valid_i ? head.wdata   : '0;
  assign bus.out_mstatus = out_valid_i ? head.mstatus : '0;
  assign bus.out_check   = out_valid_i & head.check;
  assign bus.almost_full = (free_slots < PW'(AF_MARGIN));
  assign bus.overflow    = overflow_q;
  assign bus.done        = done_q;
  assign bus.retired_cnt = retired_q;
endmodule

// File: tb/tb_difftest_commit_sequencer.sv
// Scoreboard bench for difftest_commit_sequencer: expected events are queued as stimulus
// is driven and compared in order as the checker side pops them.
module tb_difftest_commit_sequencer;
  typedef struct packed {
    logic        is_trap;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] wdata;
    logic [63:0] mstatus;
    logic        check;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  difftest_commit_sequencer_if bus ();

  difftest_commit_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  ev_t             exp_q[$];
  int              n_cmp = 0;
  int              n_err = 0;
  longint unsigned exp_retired = 0;

  function automatic ev_t mk_commit(input logic [63:0] pc);
    ev_t e;
    e.is_trap = 1'b0;
    e.pc      = pc;
    e.inst    = pc[31:0] ^ 32'h0000_0013;
    e.wdata   = pc ^ 64'h5A5A_5A5A_0F0F_0F0F;
    e.mstatus = {pc[31:0], pc[63:32]};
    e.check   = pc[2];
    return e;
  endfunction

  function automatic ev_t mk_trap(input logic [63:0] cause);
    ev_t e;
    e         = '0;
    e.is_trap = 1'b1;
    e.wdata   = cause;
    return e;
  endfunction

  // Invalid lanes carry junk so a design that ignored in_valid would surface it.
  task automatic clear_inputs();
    bus.in_valid   = '0;
    bus.in_pc      = {2{64'hDEAD_BEEF_0BAD_F00D}};
    bus.in_inst    = {2{32'hFFFF_FFFF}};
    bus.in_wdata   = {2{64'hBAD0_BAD0_BAD0_BAD0}};
    bus.in_mstatus = {2{64'hCCCC_CCCC_CCCC_CCCC}};
    bus.in_check   = '1;
    bus.in_trap    = 1'b0;
    bus.in_cause   = 64'hEEEE_EEEE_EEEE_EEEE;
    bus.finish_req = 1'b0;
  endtask

  task automatic drive(input logic [1:0] lanes, input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic trap, input logic [63:0] cause, input bit accept);
    logic [63:0] pcs [2];
    ev_t e;
    pcs[0] = pc0;
    pcs[1] = pc1;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      if (lanes[i]) begin
        e = mk_commit(pcs[i]);
        bus.in_valid[i]            = 1'b1;
        bus.in_pc[i*64 +: 64]      = e.pc;
        bus.in_inst[i*32 +: 32]    = e.inst;
        bus.in_wdata[i*64 +: 64]   = e.wdata;
        bus.in_mstatus[i*64 +: 64] = e.mstatus;
        bus.in_check[i]            = e.check;
        if (accept) exp_q.push_back(e);
      end
    end
    if (trap) begin
      bus.in_trap  = 1'b1;
      bus.in_cause = cause;
      if (accept) exp_q.push_back(mk_trap(cause));
    end
  endtask

  // Caller holds out_ready=1; compares the head against the scoreboard, lets it pop, checks retired_cnt.
  task automatic pop_check(input string name);
    ev_t got, e;
    int  waited = 0;
    while (!bus.out_valid && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: DUT out_valid=%0b but scoreboard empty", name, bus.out_valid);
      return;
    end
    e = exp_q.pop_front();
    if (!bus.out_valid) begin
      n_err++;
      $display("FAIL %s: timeout, out_valid=0, expected pc=%h trap=%0b", name, e.pc, e.is_trap);
      return;
    end
    got = '{is_trap: bus.out_is_trap, pc: bus.out_pc, inst: bus.out_inst,
            wdata: bus.out_wdata, mstatus: bus.out_mstatus, check: bus.out_check};
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: event got trap=%0b pc=%h inst=%h wdata=%h mst=%h chk=%0b expected trap=%0b pc=%h inst=%h wdata=%h mst=%h chk=%0b",
               name, got.is_trap, got.pc, got.inst, got.wdata, got.mstatus, got.check,
               e.is_trap, e.pc, e.inst, e.wdata, e.mstatus, e.check);
    end
    if (!e.is_trap) exp_retired++;
    @(negedge clock);
    n_cmp++;
    if (bus.retired_cnt !== exp_retired) begin
      n_err++;
      $display("FAIL %s retired_cnt: got %0d expected %0d", name, bus.retired_cnt, exp_retired);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.out_ready = 1'b0;
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    exp_retired = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.out_ready = 1'b1;
    #1 reset = 1'b1;
    #12;
    n_cmp++;
    if ({bus.out_valid, bus.out_is_trap, bus.out_check, bus.almost_full, bus.overflow, bus.done} !== 6'b0) begin
      n_err++;
      $display("FAIL reset flags: got v/t/c/af/ov/d=%b expected 000000",
               {bus.out_valid, bus.out_is_trap, bus.out_check, bus.almost_full, bus.overflow, bus.done});
    end
    n_cmp++;
    if ({bus.out_pc, bus.out_inst, bus.out_wdata, bus.out_mstatus, bus.retired_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset data: got pc=%h wdata=%h retired=%0d expected all 0",
               bus.out_pc, bus.out_wdata, bus.retired_cnt);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset idle out_valid: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_sparse();
    bus.out_ready = 1'b1;
    drive(2'b10, 64'h1111, 64'h8000_0004, 1'b0, '0, 1'b1);
    @(negedge clock);
    clear_inputs();
    pop_check("sparse_lane1");
  endtask

  task automatic test_trap_order();
    bus.out_ready = 1'b1;
    drive(2'b11, 64'h100, 64'h104, 1'b1, 64'h8000_0000_0000_0007, 1'b1);
    @(negedge clock);
    clear_inputs();
    pop_check("trap_order_c0");
    pop_check("trap_order_c1");
    pop_check("trap_order_trap");
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(2'b11, 64'h2000, 64'h2004, 1'b0, '0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (c == 0) drive(2'b01, 64'h2008, 64'h0, 1'b0, '0, 1'b1);
      else if (c == 1) drive(2'b11, 64'h200C, 64'h2010, 1'b0, '0, 1'b1);
      else clear_inputs();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_q[0].pc || bus.out_wdata !== exp_q[0].wdata) begin
        n_err++;
        $display("FAIL backpressure hold c%0d: got v=%b pc=%h expected v=1 pc=%h", c, bus.out_valid, bus.out_pc, exp_q[0].pc);
      end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) pop_check($sformatf("backpressure_pop%0d", k));
  endtask

  // Enqueue and dequeue in the same cycles while occupancy grows; pointers wrap past DEPTH.
  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive(2'b01, 64'h3000, 64'h0, 1'b0, '0, 1'b1);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, 64'h3100 + 64'(16 * k), 64'h3108 + 64'(16 * k), 1'b0, '0, 1'b1);
      pop_check($sformatf("b2b_overlap%0d", k));
    end
    clear_inputs();
    for (int k = 0; k < 6; k++) pop_check($sformatf("b2b_tail%0d", k));
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(2'b11, 64'h4000 + 64'(16 * c), 64'h4008 + 64'(16 * c), 1'b0, '0, 1'b1);
      @(negedge clock);
      if (c == 4) begin
        n_cmp++;
        if (bus.almost_full !== 1'b0) begin
          n_err++;
          $display("FAIL almost_full at occ10: got %b expected 0", bus.almost_full);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (bus.almost_full !== 1'b1) begin
          n_err++;
          $display("FAIL almost_full at occ12: got %b expected 1", bus.almost_full);
        end
      end
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.overflow !== 1'b0 || bus.out_pc !== exp_q[0].pc) begin
      n_err++;
      $display("FAIL full pre-overflow: got v=%b ov=%b pc=%h expected v=1 ov=0 pc=%h",
               bus.out_valid, bus.overflow, bus.out_pc, exp_q[0].pc);
    end
    // 17th commit with a same-cycle pop: the pop is not credited, so it overflows anyway.
    drive(2'b01, 64'h4F00, 64'h0, 1'b0, '0, 1'b0);
    bus.out_ready = 1'b1;
    void'(exp_q.pop_front());
    exp_retired++;
    @(negedge clock);
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (bus.overflow !== 1'b1 || bus.out_valid !== 1'b0 || bus.retired_cnt !== exp_retired) begin
        n_err++;
        $display("FAIL overflow c%0d: got ov=%b v=%b retired=%0d expected ov=1 v=0 retired=%0d",
                 c, bus.overflow, bus.out_valid, bus.retired_cnt, exp_retired);
      end
      @(negedge clock);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.out_valid !== 1'b0 || bus.almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL overflow async clear: got ov=%b v=%b af=%b expected 0 0 0", bus.overflow, bus.out_valid, bus.almost_full);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    exp_retired = 0;
  endtask

  task automatic test_finish_empty();
    do_reset();
    bus.finish_req = 1'b1;
    @(negedge clock);
    bus.finish_req = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL finish_empty +1: got done=%b expected 0", bus.done);
    end
    @(negedge clock);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL finish_empty +2: got done=%b v=%b expected done=1 v=0", bus.done, bus.out_valid);
    end
  endtask

  task automatic test_drain();
    do_reset();
    drive(2'b11, 64'h5000, 64'h5004, 1'b0, '0, 1'b1);
    @(negedge clock);
    drive(2'b01, 64'h5008, 64'h0, 1'b0, '0, 1'b1);
    @(negedge clock);
    drive(2'b01, 64'h500C, 64'h0, 1'b0, '0, 1'b1);
    bus.finish_req = 1'b1;
    @(negedge clock);
    drive(2'b11, 64'h5F00, 64'h5F04, 1'b1, 64'h3, 1'b0);
    @(negedge clock);
    clear_inputs();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) pop_check($sformatf("drain_pop%0d", k));
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL drain early done: got %b expected 0", bus.done);
    end
    pop_check("drain_pop3");
    n_cmp++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain done: got done=%b v=%b expected done=1 v=0", bus.done, bus.out_valid);
    end
    drive(2'b11, 64'h6000, 64'h6004, 1'b0, '0, 1'b0);
    @(negedge clock);
    clear_inputs();
    @(negedge clock);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.retired_cnt !== exp_retired) begin
      n_err++;
      $display("FAIL done hold: got done=%b v=%b retired=%0d expected 1 0 %0d",
               bus.done, bus.out_valid, bus.retired_cnt, exp_retired);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(2'b11, 64'h7000, 64'h7004, 1'b0, '0, 1'b1);
    @(negedge clock);
    clear_inputs();
    bus.finish_req = 1'b1;
    @(negedge clock);
    bus.finish_req = 1'b0;
    bus.out_ready = 1'b1;
    pop_check("async_pre_pop");
    bus.out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0 || bus.retired_cnt !== 64'd0) begin
      n_err++;
      $display("FAIL async reset: got v=%b done=%b ov=%b retired=%0d expected 0 0 0 0",
               bus.out_valid, bus.done, bus.overflow, bus.retired_cnt);
    end
    #4 reset = 1'b0;
    exp_q.delete();
    exp_retired = 0;
    @(negedge clock);
    bus.out_ready = 1'b1;
    drive(2'b01, 64'h7100, 64'h0, 1'b0, '0, 1'b1);
    @(negedge clock);
    clear_inputs();
    pop_check("async_fresh");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sparse();
    test_trap_order();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_finish_empty();
    test_drain();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
